// File: rtl/fxp_divider_if.sv
// Operand/result bundle for the sequential fixed-point divider.
// master drives the request side; slave is the divider.
interface fxp_divider_if #(
    parameter int W  = 12,
    parameter int QW = 16
);
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [QW-1:0] q;
    logic          ovf;
    logic          dbz;

    modport master (
        output start, a, b,
        input  busy, done, q, ovf, dbz
    );

    modport slave (
        input  start, a, b,
        output busy, done, q, ovf, dbz
    );
endinterface

// File: rtl/fxp_divider.sv
// Signed fixed-point divider q = (a <<< FRAC) / b, restoring shift-subtract, one quotient bit per clock.
// Latency: done pulses W+FRAC+1 edges after the accepting edge, for every operand pair including b=0.
// Backpressure: none; start is sampled only in IDLE and requests arriving while busy are dropped.
module fxp_divider #(
    parameter int W    = 12,
    parameter int FRAC = 8,
    parameter int QW   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    fxp_divider_if.slave  dif
);
    localparam int DW = W + FRAC;
    localparam int MW = W + 1;
    localparam int CW = $clog2(DW);

    localparam logic [DW-1:0] POS_LIM = DW'((1 << (QW - 1)) - 1);
    localparam logic [DW-1:0] NEG_LIM = DW'(1 << (QW - 1));
    localparam logic [QW-1:0] Q_MAX   = {1'b0, {(QW - 1){1'b1}}};
    localparam logic [QW-1:0] Q_MIN   = {1'b1, {(QW - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [DW-1:0]  dvd_q,   dvd_d;
    logic [MW-1:0]  rem_q,   rem_d;
    logic [MW-1:0]  div_q,   div_d;
    logic           sign_q,  sign_d;
    logic           aneg_q,  aneg_d;
    logic           bz_q,    bz_d;
    logic [QW-1:0]  q_q,     q_d;
    logic           ovf_q,   ovf_d;
    logic           dbz_q,   dbz_d;
    logic           done_q,  done_d;

    logic [MW-1:0]  a_ext, b_ext, a_mag, b_mag;
    logic [MW:0]    rem_sh, trial;
    logic           qbit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        div_d   = div_q;
        sign_d  = sign_q;
        aneg_d  = aneg_q;
        bz_d    = bz_q;
        q_d     = q_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        // One extra magnitude bit so |-2^(W-1)| is representable.
        a_ext = {dif.a[W-1], dif.a};
        b_ext = {dif.b[W-1], dif.b};
        a_mag = a_ext[MW-1] ? (~a_ext + 1'b1) : a_ext;
        b_mag = b_ext[MW-1] ? (~b_ext + 1'b1) : b_ext;

        rem_sh = {rem_q, dvd_q[DW-1]};
        trial  = rem_sh - {1'b0, div_q};
        qbit   = ~trial[MW];

        unique case (state_q)
            IDLE: begin
                if (dif.start) begin
                    sign_d  = dif.a[W-1] ^ dif.b[W-1];
                    aneg_d  = dif.a[W-1];
                    bz_d    = (dif.b == '0);
                    dvd_d   = DW'({a_mag, {FRAC{1'b0}}});
                    div_d   = b_mag;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Quotient bits enter the low end as dividend bits leave the top.
                rem_d = MW'(qbit ? trial : rem_sh);
                dvd_d = {dvd_q[DW-2:0], qbit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (bz_q) begin
                    dbz_d = 1'b1;
                    ovf_d = 1'b0;
                    q_d   = aneg_q ? Q_MIN : Q_MAX;
                end else if (!sign_q) begin
                    dbz_d = 1'b0;
                    if (dvd_q > POS_LIM) begin
                        ovf_d = 1'b1;
                        q_d   = Q_MAX;
                    end else begin
                        ovf_d = 1'b0;
                        q_d   = QW'(dvd_q);
                    end
                end else begin
                    // Negating a zero magnitude yields zero, so no -0 case exists.
                    dbz_d = 1'b0;
                    if (dvd_q > NEG_LIM) begin
                        ovf_d = 1'b1;
                        q_d   = Q_MIN;
                    end else begin
                        ovf_d = 1'b0;
                        q_d   = QW'(DW'(0) - dvd_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            sign_q  <= 1'b0;
            aneg_q  <= 1'b0;
            bz_q    <= 1'b0;
            q_q     <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            sign_q  <= sign_d;
            aneg_q  <= aneg_d;
            bz_q    <= bz_d;
            q_q     <= q_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign dif.busy = (state_q != IDLE);
    assign dif.done = done_q;
    assign dif.q    = q_q;
    assign dif.ovf  = ovf_q;
    assign dif.dbz  = dbz_q;
endmodule

// File: tb/tb_fxp_divider.sv
// Bench for fxp_divider: scoreboard of reference quotients, latency and handshake checks.
module tb_fxp_divider;
    localparam int W  = 12;
    localparam int QW = 16;
    localparam int LAT = 21;

    typedef struct packed {
        logic [QW-1:0] q;
        logic          ovf;
        logic          dbz;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    res_t sb[$];

    fxp_divider_if #(.W(W), .QW(QW)) dif ();

    fxp_divider #(.W(W), .FRAC(8), .QW(QW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dif   (dif.slave)
    );

    always #5 clk = ~clk;

    // Reference: exact integer division (truncates toward zero), then saturate.
    function automatic res_t model(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        res_t   r;
        longint num;
        longint qt;
        r = '0;
        if (b == 0) begin
            r.dbz = 1'b1;
            r.q   = (a < 0) ? 16'h8000 : 16'h7FFF;
        end else begin
            num = longint'(a) * 256;
            qt  = num / longint'(b);
            if (qt > 32767) begin
                r.q = 16'h7FFF; r.ovf = 1'b1;
            end else if (qt < -32768) begin
                r.q = 16'h8000; r.ovf = 1'b1;
            end else begin
                r.q = qt[15:0];
            end
        end
        return r;
    endfunction

    function automatic res_t pop_exp();
        res_t r;
        r = '1;
        if (sb.size() > 0) r = sb.pop_front();
        return r;
    endfunction

    // Called #1 after a clock edge; returns #1 after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        dif.start = 1'b1;
        dif.a = a;
        dif.b = b;
        sb.push_back(model(a, b));
        @(posedge clk); #1;
        dif.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (dif.done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        tests++;
        if ({dif.busy, dif.done, dif.q, dif.ovf, dif.dbz} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b done=%b q=%h ovf=%b dbz=%b, required all 0",
                     dif.busy, dif.done, dif.q, dif.ovf, dif.dbz);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [10];
        logic [W-1:0] tb_ [10];
        int   n;
        res_t e;
        ta = '{12'h300, 12'hA72, 12'h472, 12'h7FF, 12'h800, 12'h800, 12'h100, 12'hF00, 12'h000, 12'h001};
        tb_ = '{12'h200, 12'h472, 12'hA72, 12'h001, 12'h001, 12'h010, 12'h000, 12'h000, 12'h5A5, 12'h7FF};
        for (int i = 0; i < 10; i++) begin
            issue(ta[i], tb_[i]);
            wait_done(n);
            tests++;
            if (n !== LAT) begin
                fails++;
                $display("FAIL directed_latency[%0d]: done after %0d edges, required %0d", i, n, LAT);
            end
            e = pop_exp();
            tests++;
            if ({dif.q, dif.ovf, dif.dbz} !== e) begin
                fails++;
                $display("FAIL directed_result[%0d] a=%h b=%h: q=%h ovf=%b dbz=%b, required q=%h ovf=%b dbz=%b",
                         i, ta[i], tb_[i], dif.q, dif.ovf, dif.dbz, e.q, e.ovf, e.dbz);
            end
            @(posedge clk); #1;
            tests++;
            if ({dif.done, dif.busy, dif.q, dif.ovf, dif.dbz} !== {2'b00, e}) begin
                fails++;
                $display("FAIL directed_hold[%0d]: done=%b busy=%b q=%h, required done=0 busy=0 q=%h",
                         i, dif.done, dif.busy, dif.q, e.q);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        int   n;
        res_t e;
        for (int i = 0; i < 8; i++) begin
            a = W'($urandom);
            b = W'($urandom_range(0, 4095));
            issue(a, b);
            wait_done(n);
            e = pop_exp();
            tests++;
            if (n !== LAT || {dif.q, dif.ovf, dif.dbz} !== e) begin
                fails++;
                $display("FAIL random[%0d] a=%h b=%h: lat=%0d q=%h ovf=%b dbz=%b, required lat=%0d q=%h ovf=%b dbz=%b",
                         i, a, b, n, dif.q, dif.ovf, dif.dbz, LAT, e.q, e.ovf, e.dbz);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int   n;
        int   extra;
        res_t e;
        issue(12'h300, 12'h200);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 5) begin
                tests++;
                if (dif.busy !== 1'b1) begin
                    fails++;
                    $display("FAIL busy_mid_calc: busy=%b, required 1", dif.busy);
                end
                dif.start = 1'b1;
                dif.a = 12'h123;
                dif.b = 12'h045;
            end
            if (i == 6) dif.start = 1'b0;
            if (dif.done) begin
                n = i;
                break;
            end
        end
        e = pop_exp();
        tests++;
        if (n !== LAT || {dif.q, dif.ovf, dif.dbz} !== e) begin
            fails++;
            $display("FAIL busy_ignore: lat=%0d q=%h, required lat=%0d q=%h", n, dif.q, LAT, e.q);
        end
        extra = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (dif.done) extra++;
        end
        tests++;
        if (extra !== 0) begin
            fails++;
            $display("FAIL busy_no_queue: %0d extra done pulses, required 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] pa [3];
        logic [W-1:0] pb [3];
        int   want [3];
        int   k;
        res_t e;
        pa = '{12'h300, 12'hA72, 12'h800};
        pb = '{12'h200, 12'h472, 12'h010};
        want = '{21, 43, 65};
        for (int i = 0; i < 3; i++) sb.push_back(model(pa[i], pb[i]));
        dif.a = pa[0];
        dif.b = pb[0];
        dif.start = 1'b1;
        @(posedge clk); #1;
        k = 0;
        for (int e_cnt = 1; e_cnt <= 80 && k < 3; e_cnt++) begin
            @(posedge clk); #1;
            if (dif.done) begin
                e = pop_exp();
                tests++;
                if (e_cnt !== want[k] || {dif.q, dif.ovf, dif.dbz} !== e) begin
                    fails++;
                    $display("FAIL back_to_back[%0d]: done at edge %0d q=%h, required edge %0d q=%h",
                             k, e_cnt, dif.q, want[k], e.q);
                end
                k++;
                if (k < 3) begin
                    dif.a = pa[k];
                    dif.b = pb[k];
                end else begin
                    dif.start = 1'b0;
                end
            end
        end
        dif.start = 1'b0;
        tests++;
        if (k !== 3) begin
            fails++;
            $display("FAIL back_to_back_count: %0d results, required 3", k);
        end
        while (sb.size() > 0) void'(sb.pop_front());
        repeat (25) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort();
        int   n;
        int   seen;
        res_t e;
        issue(12'h7FF, 12'h001);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({dif.busy, dif.done, dif.q, dif.ovf, dif.dbz} !== '0) begin
            fails++;
            $display("FAIL abort_outputs: busy=%b done=%b q=%h ovf=%b dbz=%b, required all 0",
                     dif.busy, dif.done, dif.q, dif.ovf, dif.dbz);
        end
        void'(pop_exp());
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (dif.done || dif.busy) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL abort_no_done: %0d cycles with done/busy after release, required 0", seen);
        end
        issue(12'hF00, 12'h300);
        wait_done(n);
        e = pop_exp();
        tests++;
        if (n !== LAT || {dif.q, dif.ovf, dif.dbz} !== e) begin
            fails++;
            $display("FAIL abort_recover: lat=%0d q=%h ovf=%b dbz=%b, required lat=%0d q=%h ovf=%b dbz=%b",
                     n, dif.q, dif.ovf, dif.dbz, LAT, e.q, e.ovf, e.dbz);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dif.start = 1'b0;
        dif.a = '0;
        dif.b = '0;
        #22 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
